// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector, jump flush, fetch/MEM memory arbitration and
// stale-fetch discard tracking for the five-stage core.
module pipe_ctrl #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic               mem_req,
    input  logic               mem_done,
    input  logic               id_load_use,
    input  logic               ex_jump,
    output logic [STALL_W-1:0] stall_state,
    output logic               jump_flag,
    output logic               grant_if,
    output logic               grant_mem,
    output logic               fetch_valid,
    output logic [1:0]         arb_state
);

    // Handshake: a grant holds until the controller's one-cycle mem_done pulse;
    // mem_done outside a granted transaction is ignored.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MEMOP = 2'd2
    } arb_e;

    localparam logic [STALL_W-1:0] STALL_MEM   = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] STALL_LOAD  = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_FETCH = STALL_W'(6'b000011);

    arb_e state_q;
    logic discard_q;
    logic grant_if_q;
    logic grant_mem_q;

    logic mem_stall;
    logic fetch_stall;

    // A MEM op finishing this cycle releases the pipe in the same cycle.
    assign mem_stall   = mem_req && !((state_q == MEMOP) && mem_done);
    assign jump_flag   = ex_jump && !mem_stall;
    assign fetch_valid = (state_q == FETCH) && mem_done && !discard_q && !jump_flag;
    assign fetch_stall = if_req && !fetch_valid;

    always_comb begin
        stall_state = '0;
        if (mem_stall) begin
            stall_state = STALL_MEM;
        end else if (id_load_use) begin
            stall_state = STALL_LOAD;
        end else if (fetch_stall) begin
            stall_state = STALL_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            discard_q   <= 1'b0;
            grant_if_q  <= 1'b0;
            grant_mem_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        state_q     <= MEMOP;
                        grant_mem_q <= 1'b1;
                    end else if (if_req) begin
                        state_q    <= FETCH;
                        grant_if_q <= 1'b1;
                    end
                end
                FETCH: begin
                    // A jump coinciding with mem_done is killed via fetch_valid instead.
                    if (mem_done) begin
                        state_q    <= IDLE;
                        grant_if_q <= 1'b0;
                        discard_q  <= 1'b0;
                    end else if (jump_flag) begin
                        discard_q <= 1'b1;
                    end
                end
                MEMOP: begin
                    if (mem_done) begin
                        state_q     <= IDLE;
                        grant_mem_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    grant_if_q  <= 1'b0;
                    grant_mem_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_if  = grant_if_q;
    assign grant_mem = grant_mem_q;
    assign arb_state = state_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core. It generates `stall_state` and `jump_flag`, which every inter-stage register consumes to decide hold, bubble or pass. It also arbitrates the single-port memory controller between instruction fetch and the MEM stage. When a jump is resolved while a fetch is in flight, it records the fetch so the stale instruction is discarded.

## Interface

Parameters:
- `STALL_W`, default 6: width of `stall_state`. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  IF needs an instruction word
- `mem_req`  in  1  MEM stage holds a load/store
- `mem_done`  in  1  one-cycle pulse from memory controller: granted transaction complete
- `id_load_use`  in  1  ID operand depends on the load currently in EX
- `ex_jump`  in  1  EX resolved a taken branch or jump this cycle
- `stall_state`  out  STALL_W  per-stage stall vector
- `jump_flag`  out  1  flush IF/ID and ID/EX this cycle
- `grant_if`  out  1  memory controller serves fetch (registered)
- `grant_mem`  out  1  memory controller serves MEM (registered)
- `fetch_valid`  out  1  completed fetch word may enter IF/ID

## Operation

Stage-register rule, which every consumer applies:
- `stall_state[i+1]` = 1: the register feeding stage i+1 holds.
- `stall_state[i]` = 1 and `stall_state[i+1]` = 0: that register loads a bubble.

Arbiter FSM. States are IDLE, FETCH and MEMOP.
- IDLE:
  - `mem_req` → MEMOP. MEM has priority.
  - else `if_req` → FETCH.
  - else stay in IDLE.
- FETCH: `mem_done` → IDLE. A pending `mem_req` waits; there is no preemption.
- MEMOP: `mem_done` → IDLE.
- `grant_if` = (state == FETCH). `grant_mem` = (state == MEMOP).

Stall vector. Combinational; the first matching row wins.
- mem_stall = `mem_req` and not (MEMOP and `mem_done`) → 6'b011111.
- `id_load_use` → 6'b000111.
- fetch_stall = `if_req` and not `fetch_valid` → 6'b000011.
- otherwise → 6'b000000.

Jump handling:
- `jump_flag` = `ex_jump` and not mem_stall. When EX is held, the jump is re-presented next cycle, so it is not flushed early.
- `discard` register:
  - Set when `jump_flag` = 1 and state == FETCH and `mem_done` = 0.
  - Cleared on `mem_done` while in FETCH.
  - `jump_flag` together with `mem_done` in FETCH does not set it. That word is killed directly by the `fetch_valid` term below.
- `fetch_valid` = FETCH and `mem_done` and not `discard` and not `jump_flag`.

Reset:
- State goes to IDLE and `discard` to 0.
- Registered outputs are 0. Combinational outputs follow their inputs.
- Reset mid-transaction abandons it. The memory controller shares `rst` and aborts too.

## Timing

- Grant latency: a request seen in IDLE at edge N gives a grant during cycle N+1.
- Minimum fetch: the request cycle, then `mem_done` at the earliest in the first granted cycle. Back-to-back fetches therefore pass through IDLE for one cycle.
- `stall_state`, `jump_flag` and `fetch_valid` are same-cycle combinational and are sampled by the stage registers at the next edge.
- Simultaneous `mem_req` and `if_req` in IDLE: MEMOP wins. IF remains stalled with 6'b011111 until MEM completes.
- `mem_done` while IDLE is ignored. It is an illegal input and is not a state change.
- `ex_jump` during `id_load_use`:
  - `jump_flag` = 1 and the stall vector is 6'b000111.
  - ID/EX obeys the bubble from `stall_state[2]`. The jump also flushes IF/ID, and the jumping instruction proceeds.
- Discard persistence: a discarded fetch suppresses `fetch_valid` exactly once. The next fetch after IDLE is valid.

## Test plan

- Reset, then `if_req`=1 → `grant_if`=1 next cycle. `mem_done` pulse → `fetch_valid`=1 and `stall_state`=0 for that cycle. Before the pulse, `stall_state`=6'b000011.
- `if_req`=`mem_req`=1 in IDLE → `grant_mem`=1 and `stall_state`=6'b011111. After `mem_done`, the FSM passes IDLE → FETCH and `grant_if`=1.
- FETCH in progress, `ex_jump` pulse with no `mem_done` → `jump_flag`=1. The next `mem_done` gives `fetch_valid`=0. The following fetch gives `fetch_valid`=1.
- `ex_jump`=1 while `mem_req`=1 and MEMOP is not done → `jump_flag`=0. In the cycle `mem_done` arrives → `jump_flag`=1 and `stall_state`=6'b000000.
- `id_load_use`=1 for one cycle → `stall_state`=6'b000111 for exactly that cycle.
- `rst` asserted in MEMOP → next cycle `grant_mem`=0 and the state is IDLE. A subsequent `mem_done` has no effect.
